serial_alu_w: RTL and testbench

Word-framed, parametrised bit-serial ALU for the sequential datapath. It consumes operands a and b LSB-first, one bit per clock, and produces the result LSB-first with one cycle of latency. It tracks its own bit position, so the caller issues only a start strobe. At the end of each word it reports Z/C/N/V flags. A chain mode builds multi-word arithmetic out of consecutive words.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_bitslice.sv | 35 +++
 rtl/serial_alu_w.sv | 154 +++++++++++++++
 tb/tb_serial_alu_w.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode constants, FSM encoding and carry helpers for serial_alu_w
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_XNOR = 3'd6;
    localparam logic [2:0] ALU_CMP  = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP);
    endfunction

    // Subtraction is a + ~b + 1, so SUB/CMP seed the carry with 1
    function automatic logic carry_init(input logic [2:0] op);
        return (op != ALU_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bitslice.sv
`default_nettype none
// ============================================================================
// alu_bitslice : one-bit full adder plus logic mux for the serial ALU
// Revision : 1.0
// ============================================================================
module alu_bitslice
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       y,
    output logic       cout
);

    logic w_b_eff;
    logic w_sum;

    always_comb begin
        w_b_eff = (op == ALU_ADD) ? b : ~b;
        w_sum   = a ^ w_b_eff ^ cin;
        cout    = (a & w_b_eff) | (cin & (a ^ w_b_eff));
        case (op)
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_XOR:  y = a ^ b;
            ALU_NOT:  y = ~a;
            ALU_XNOR: y = ~(a ^ b);
            default:  y = w_sum;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu_w.sv
`default_nettype none
// ============================================================================
// serial_alu_w : word-framed LSB-first bit-serial ALU with Z/C/N/V flags
// Revision : 1.0
// ============================================================================
module serial_alu_w
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       chain,
    input  logic       a,
    input  logic       b,
    output logic       busy,
    output logic       y,
    output logic       valid,
    output logic       done,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_n,
    output logic       flag_v
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    op_q, op_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic          y_q, y_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_n_q, flag_n_d;
    logic          flag_v_q, flag_v_d;

    logic          w_accept;
    logic          w_consume;
    logic          w_last;
    logic [2:0]    w_op;
    logic          w_cin;
    logic          w_zin;
    logic          w_y;
    logic          w_cout;

    assign w_accept  = (state_q == ST_IDLE) && start;
    assign w_consume = w_accept || (state_q == ST_RUN);
    assign w_last    = (state_q == ST_RUN) && (count_q == LAST);
    assign w_op      = w_accept ? opcode : op_q;
    // Bit 0 seeds carry and Z from the start-cycle chain input and held flags
    assign w_cin     = w_accept ? (chain ? flag_c_q : carry_init(opcode)) : carry_q;
    assign w_zin     = w_accept ? (~chain | flag_z_q) : zacc_q;

    alu_bitslice u_slice (
        .op   (w_op),
        .a    (a),
        .b    (b),
        .cin  (w_cin),
        .y    (w_y),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= ALU_ADD;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            y_q      <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (count_q == LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        y_d      = 1'b0;
        valid_d  = w_consume;
        done_d   = w_last;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;

        if (w_accept) begin
            op_d    = opcode;
            count_d = CW'(1);
        end else if (state_q == ST_RUN) begin
            count_d = w_last ? '0 : count_q + 1'b1;
        end

        if (w_consume) begin
            y_d    = (w_op == ALU_CMP) ? 1'b0 : w_y;
            zacc_d = w_zin & ~w_y;
            if (is_arith(w_op)) carry_d = w_cout;
        end

        // Flags come from the MSB slice; its carry-in is the V reference
        if (w_last) begin
            flag_z_d = w_zin & ~w_y;
            flag_c_d = is_arith(w_op) & w_cout;
            flag_n_d = w_y;
            flag_v_d = is_arith(w_op) & (w_cin ^ w_cout);
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign y      = y_q;
    assign valid  = valid_q;
    assign done   = done_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_n = flag_n_q;
    assign flag_v = flag_v_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_w.sv
`default_nettype none
// ============================================================================
// tb_serial_alu_w : randomized and directed bench for serial_alu_w (WIDTH=8)
// Revision : 1.0
// ============================================================================
module tb_serial_alu_w;
    import alu_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] opcode;
    logic       chain;
    logic       a;
    logic       b;
    logic       busy, y, valid, done;
    logic       flag_z, flag_c, flag_n, flag_v;

    int n_checks = 0;
    int n_errors = 0;

    logic         exp_z, exp_c, exp_n, exp_v;
    logic [W-1:0] last_y;
    logic [3:0]   last_fl;

    serial_alu_w #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .chain  (chain),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .y      (y),
        .valid  (valid),
        .done   (done),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_n (flag_n),
        .flag_v (flag_v)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One word, back-to-back capable: start at the next negedge, bits follow.
    task automatic run_word(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic ch, input int glitch_bit);
        logic [W:0]   s;
        logic [W-1:0] bx, res, yw;
        logic         cin, ez, ec, en, ev;
        logic [3:0]   old_fl;
        int           bad;

        // Word-level reference
        cin = ch ? exp_c : (op != ALU_ADD);
        bx  = (op == ALU_ADD) ? bv : ~bv;
        s   = {1'b0, av} + {1'b0, bx} + {{W{1'b0}}, cin};
        ec  = 1'b0;
        ev  = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_CMP: begin
                res = s[W-1:0];
                ec  = s[W];
                ev  = (av[W-1] == bx[W-1]) && (res[W-1] != av[W-1]);
            end
            ALU_OR:   res = av | bv;
            ALU_AND:  res = av & bv;
            ALU_XOR:  res = av ^ bv;
            ALU_NOT:  res = ~av;
            default:  res = ~(av ^ bv);
        endcase
        ez = (res == '0) && (ch ? exp_z : 1'b1);
        en = res[W-1];

        bad    = 0;
        yw     = '0;
        old_fl = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start  = 1'b1;
                opcode = op;
                chain  = ch;
            end else begin
                start  = (i == glitch_bit) ? 1'b1 : ($urandom_range(0, 3) == 0);
                opcode = 3'($urandom);
                chain  = 1'($urandom);
            end
            a = av[i];
            b = bv[i];
            @(posedge clk);
            #1;
            yw[i] = y;
            if (valid !== 1'b1 || done !== (i == W - 1) || busy !== (i < W - 1)) bad++;
            if (i == 0) old_fl = {flag_z, flag_c, flag_n, flag_v};
        end
        check_eq({tag, "_hold"}, 32'(old_fl), 32'({exp_z, exp_c, exp_n, exp_v}));
        check_eq({tag, "_ctrl"}, 32'(bad), 32'd0);
        check_eq({tag, "_y"}, 32'(yw), 32'((op == ALU_CMP) ? '0 : res));
        check_eq({tag, "_flags"}, 32'({flag_z, flag_c, flag_n, flag_v}), 32'({ez, ec, en, ev}));
        exp_z   = ez;
        exp_c   = ec;
        exp_n   = en;
        exp_v   = ev;
        last_y  = yw;
        last_fl = {flag_z, flag_c, flag_n, flag_v};
    endtask

    task automatic idle(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 1'($urandom);
            b     = 1'($urandom);
            @(posedge clk);
            #1;
            if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        if (n > 0) check_eq("idle_quiet", 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; opcode = '0; chain = 1'b0; a = 1'b0; b = 1'b0;
        {exp_z, exp_c, exp_n, exp_v} = 4'b0;
        last_y = '0; last_fl = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", 32'({y, valid, done, busy, flag_z, flag_c, flag_n, flag_v}), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_word("add", ALU_ADD, 8'h5A, 8'h3C, 1'b0, -1);
        check_eq("add_dir_y", 32'(last_y), 32'h96);
        check_eq("add_dir_fl", 32'(last_fl), 32'b0011);
        idle(1);
        run_word("sub", ALU_SUB, 8'h10, 8'h20, 1'b0, -1);
        check_eq("sub_dir_y", 32'(last_y), 32'hF0);
        check_eq("sub_dir_fl", 32'(last_fl), 32'b0010);
        run_word("cmp", ALU_CMP, 8'h33, 8'h33, 1'b0, -1);
        check_eq("cmp_dir_y", 32'(last_y), 32'h00);
        check_eq("cmp_dir_fl", 32'(last_fl), 32'b1100);

        run_word("chain1", ALU_ADD, 8'hFF, 8'h01, 1'b0, -1);
        check_eq("chain1_dir_fl", 32'(last_fl), 32'b1100);
        run_word("chain2", ALU_ADD, 8'h00, 8'h00, 1'b1, -1);
        check_eq("chain2_dir_y", 32'(last_y), 32'h01);
        check_eq("chain2_dir_fl", 32'(last_fl), 32'b0000);

        run_word("xnor", ALU_XNOR, 8'hF0, 8'hAA, 1'b0, -1);
        check_eq("xnor_dir_y", 32'(last_y), 32'hA5);
        check_eq("xnor_dir_fl", 32'(last_fl), 32'b0010);
        run_word("not", ALU_NOT, 8'h0F, 8'h5C, 1'b0, -1);
        check_eq("not_dir_y", 32'(last_y), 32'hF0);
        run_word("and", ALU_AND, 8'hC3, 8'h0F, 1'b0, -1);
        check_eq("and_dir_y", 32'(last_y), 32'h03);
        check_eq("and_dir_fl", 32'(last_fl), 32'b0000);

        idle(2);
        run_word("glitch", ALU_ADD, 8'h5A, 8'h3C, 1'b0, 3);
        check_eq("glitch_dir_y", 32'(last_y), 32'h96);

        // Reset lands mid-word, between edges
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 0); opcode = ALU_ADD; chain = 1'b0; a = 1'b1; b = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        a = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst", 32'({y, valid, done, busy, flag_z, flag_c, flag_n, flag_v}), 32'd0);
        {exp_z, exp_c, exp_n, exp_v} = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || valid !== 1'b0) bad++;
        end
        check_eq("no_done_after_rst", 32'(bad), 32'd0);

        run_word("post_rst_chain", ALU_ADD, 8'h01, 8'h01, 1'b1, -1);
        check_eq("post_rst_dir_y", 32'(last_y), 32'h02);
        check_eq("post_rst_dir_fl", 32'(last_fl), 32'b0000);

        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            run_word("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                     1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
